// File: rtl/wait_state_ram_pkg.sv
// Shared encodings and FSM state type for the wait-state RAM.
package wait_state_ram_pkg;

    localparam logic [1:0] DT_BYTE = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_WORD = 2'b10;
    localparam logic [1:0] DT_RSVD = 2'b11;

    localparam logic WRITE  = 1'b1;
    localparam logic ENABLE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Number of bytes touched by an access; 0 for the reserved encoding.
    function automatic logic [2:0] access_bytes(input logic [1:0] dt);
        case (dt)
            DT_BYTE: access_bytes = 3'd1;
            DT_HALF: access_bytes = 3'd2;
            DT_WORD: access_bytes = 3'd4;
            default: access_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering and alignment check for one 32-bit word slot.
// Lane k is the byte at word_base+k; data is right-justified on the bus side.
module mem_lane_align
    import wait_state_ram_pkg::*;
#(
    parameter int BIG_ENDIAN = 1
) (
    input  logic [1:0]  offs,
    input  logic [1:0]  data_type,
    input  logic [31:0] wdata,
    input  logic [31:0] rlane,
    output logic        misalign,
    output logic [3:0]  be,
    output logic [31:0] wlane,
    output logic [31:0] rdata
);

    logic [2:0] nbytes;
    logic [1:0] lane [4];
    logic [1:0] src  [4];

    assign nbytes = access_bytes(data_type);

    // Fault on the reserved size or any access not aligned to its own size.
    always_comb begin
        misalign = (data_type == DT_RSVD) ||
                   (data_type == DT_HALF && offs[0]) ||
                   (data_type == DT_WORD && offs != 2'b00);
    end

    // Access byte i lives in lane offs+i and maps to bus byte src[i].
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane[i] = offs + 2'(i);
            src[i]  = (BIG_ENDIAN != 0) ? 2'(nbytes - 3'd1 - 3'(i)) : 2'(i);
        end
    end

    // Scatter write bytes into lanes and gather read bytes, zero-extended.
    always_comb begin
        be    = '0;
        wlane = '0;
        rdata = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < nbytes) begin
                be[lane[i]]                   = 1'b1;
                wlane[{lane[i], 3'b000} +: 8] = wdata[{src[i], 3'b000} +: 8];
                rdata[{src[i], 3'b000} +: 8]  = rlane[{lane[i], 3'b000} +: 8];
            end
        end
    end

endmodule

// File: rtl/wait_state_ram.sv
// Byte-addressed RAM with a fixed number of wait states and an mfa/mfc
// handshake. The array is never reset so a bench can preload it.
module wait_state_ram
    import wait_state_ram_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2,
    parameter int BIG_ENDIAN  = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              mfa,
    input  logic              MemEN,
    input  logic              r_w,
    input  logic [1:0]        dataType,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              mfc,
    output logic              err
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic [7:0] ram [0:DEPTH-1];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mfc_q, mfc_d;
    logic              err_q, err_d;
    logic [31:0]       dout_q, dout_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        dtype_q, dtype_d;
    logic              rw_q, rw_d;

    logic              fire;
    logic              we;
    logic              misalign;
    logic [3:0]        be;
    logic [31:0]       wlane;
    logic [31:0]       rlane;
    logic [31:0]       rdata;
    logic [ADDR_W-3:0] word_q;

    assign word_q = addr_q[ADDR_W-1:2];

    // Present the four bytes of the captured word slot to the lane steering.
    always_comb begin
        rlane = {ram[{word_q, 2'd3}], ram[{word_q, 2'd2}],
                 ram[{word_q, 2'd1}], ram[{word_q, 2'd0}]};
    end

    mem_lane_align #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_align (
        .offs     (addr_q[1:0]),
        .data_type(dtype_q),
        .wdata    (wdata_q),
        .rlane    (rlane),
        .misalign (misalign),
        .be       (be),
        .wlane    (wlane),
        .rdata    (rdata)
    );

    // Handshake FSM: capture in IDLE, count down in BUSY, hold mfc in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mfc_d   = mfc_q;
        err_d   = err_q;
        dout_d  = dout_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dtype_d = dtype_q;
        rw_d    = rw_q;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                mfc_d = 1'b0;
                err_d = 1'b0;
                if (mfa && MemEN == ENABLE) begin
                    addr_d  = addr;
                    wdata_d = data_in;
                    dtype_d = dataType;
                    rw_d    = r_w;
                    cnt_d   = WS;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!mfa) begin
                    // Requester withdrew: abandon without touching memory.
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    fire    = 1'b1;
                    mfc_d   = 1'b1;
                    err_d   = misalign;
                    if (!misalign && rw_q != WRITE) dout_d = rdata;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (!mfa) begin
                    mfc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign we = fire && !misalign && rw_q == WRITE;

    // Control and capture registers; the array below is deliberately not reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mfc_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            dtype_q <= DT_BYTE;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mfc_q   <= mfc_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dtype_q <= dtype_d;
            rw_q    <= rw_d;
        end
    end

    // Commit enabled byte lanes on the completion edge only.
    always_ff @(posedge clk) begin
        if (we) begin
            if (be[0]) ram[{word_q, 2'd0}] <= wlane[7:0];
            if (be[1]) ram[{word_q, 2'd1}] <= wlane[15:8];
            if (be[2]) ram[{word_q, 2'd2}] <= wlane[23:16];
            if (be[3]) ram[{word_q, 2'd3}] <= wlane[31:24];
        end
    end

    assign data_out = dout_q;
    assign mfc      = mfc_q;
    assign err      = err_q;

endmodule

// File: tb/tb_wait_state_ram.sv
// Randomized bench for wait_state_ram against a byte-array reference model.
module tb_wait_state_ram;

    localparam int WS_A = 2;

    logic        clk = 1'b0;
    logic        clr;
    logic        mfa, memen, r_w;
    logic [1:0]  data_type;
    logic [7:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        mfc, err;

    logic        mfa_b, memen_b, r_w_b;
    logic [1:0]  data_type_b;
    logic [7:0]  addr_b;
    logic [31:0] data_in_b;
    logic [31:0] data_out_b;
    logic        mfc_b, err_b;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem_m [256];
    logic [31:0] dout_m;

    always #5 clk = ~clk;

    wait_state_ram #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(WS_A), .BIG_ENDIAN(1)) dut_a (
        .clk(clk), .clr(clr), .mfa(mfa), .MemEN(memen), .r_w(r_w),
        .dataType(data_type), .addr(addr), .data_in(data_in),
        .data_out(data_out), .mfc(mfc), .err(err)
    );

    wait_state_ram #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(0), .BIG_ENDIAN(0)) dut_b (
        .clk(clk), .clr(clr), .mfa(mfa_b), .MemEN(memen_b), .r_w(r_w_b),
        .dataType(data_type_b), .addr(addr_b), .data_in(data_in_b),
        .data_out(data_out_b), .mfc(mfc_b), .err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Big-endian reference: byte at a is most significant.
    task automatic model_access(input logic rw, input logic [1:0] dt, input logic [7:0] a,
                                input logic [31:0] d, output logic fault);
        int sz;
        logic [31:0] v;
        sz    = 1 << dt;
        fault = (dt == 2'b11) || ((int'(a) % sz) != 0);
        if (!fault) begin
            if (rw) begin
                for (int i = 0; i < sz; i++)
                    mem_m[a + 8'(i)] = 8'(d >> (8 * (sz - 1 - i)));
            end else begin
                v = 0;
                for (int i = 0; i < sz; i++) v = (v << 8) | 32'(mem_m[a + 8'(i)]);
                dout_m = v;
            end
        end
    endtask

    task automatic do_access(input logic rw, input logic [1:0] dt, input logic [7:0] a,
                             input logic [31:0] d);
        int lat;
        logic fault;
        @(negedge clk);
        mfa = 1'b1; memen = 1'b0; r_w = rw; data_type = dt; addr = a; data_in = d;
        @(posedge clk); #1;
        // Inputs wander after capture; the access must not notice.
        addr = 8'($urandom); data_in = $urandom; data_type = 2'($urandom);
        r_w = 1'($urandom); memen = 1'($urandom);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); lat++; #1;
            if (mfc) break;
        end
        chk("latency", 32'(lat), 32'(WS_A + 1));
        model_access(rw, dt, a, d, fault);
        chk("err", 32'(err), 32'(fault));
        chk("data_out", data_out, dout_m);
        @(posedge clk); #1;
        chk("mfc_hold", 32'(mfc), 32'd1);
        @(negedge clk); mfa = 1'b0;
        @(posedge clk); #1;
        chk("mfc_clear", 32'(mfc), 32'd0);
        chk("err_clear", 32'(err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        logic [1:0] dt;
        logic [7:0] a;
        logic rw;

        clr = 1'b0; mfa = 1'b0; memen = 1'b1; r_w = 1'b0; data_type = 2'b00;
        addr = '0; data_in = '0;
        mfa_b = 1'b0; memen_b = 1'b1; r_w_b = 1'b0; data_type_b = 2'b00;
        addr_b = '0; data_in_b = '0;
        dout_m = '0;
        #12;
        chk("rst_mfc", 32'(mfc), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_dout", data_out, 32'd0);
        @(negedge clk); clr = 1'b1;

        // Give every byte a known value through the normal write path.
        for (int w = 0; w < 64; w++) do_access(1'b1, 2'b10, 8'(w * 4), $urandom);

        // Word write / read-back and byte merge.
        do_access(1'b1, 2'b10, 8'h10, 32'hDEADBEEF);
        do_access(1'b0, 2'b10, 8'h10, 32'h0);
        chk("word_rd", data_out, 32'hDEADBEEF);
        chk("ram10", 32'(dut_a.ram[8'h10]), 32'h0000_00DE);
        do_access(1'b1, 2'b00, 8'h12, 32'h0000_005A);
        do_access(1'b0, 2'b10, 8'h10, 32'h0);
        chk("merge_rd", data_out, 32'hDEAD5AEF);
        do_access(1'b0, 2'b00, 8'h13, 32'h0);
        chk("byte_rd", data_out, 32'h0000_00EF);

        // Misaligned accesses fault and change nothing.
        do_access(1'b0, 2'b10, 8'h11, 32'h0);
        chk("misal_dout", data_out, 32'h0000_00EF);
        do_access(1'b1, 2'b01, 8'h13, 32'h0000_FFFF);
        do_access(1'b0, 2'b10, 8'h10, 32'h0);
        chk("misal_nowr", data_out, 32'hDEAD5AEF);

        // Abort: drop mfa one cycle after capture.
        @(negedge clk);
        mfa = 1'b1; memen = 1'b0; r_w = 1'b1; data_type = 2'b10;
        addr = 8'h20; data_in = 32'h11111111;
        @(posedge clk);
        @(negedge clk); mfa = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (mfc) seen = 1'b1;
        end
        chk("abort_mfc", 32'(seen), 32'd0);
        chk("abort_dout", data_out, dout_m);
        for (int i = 0; i < 4; i++)
            chk("abort_ram", 32'(dut_a.ram[8'h20 + i]), 32'(mem_m[8'h20 + i]));

        // Reset in the middle of a write.
        @(negedge clk);
        mfa = 1'b1; memen = 1'b0; r_w = 1'b1; data_type = 2'b10;
        addr = 8'h30; data_in = 32'h11223344;
        @(posedge clk);
        @(negedge clk); clr = 1'b0; #1;
        chk("rstb_mfc", 32'(mfc), 32'd0);
        chk("rstb_dout", data_out, 32'd0);
        dout_m = '0;
        @(negedge clk); mfa = 1'b0; clr = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            chk("rstb_ram", 32'(dut_a.ram[8'h30 + i]), 32'(mem_m[8'h30 + i]));
        chk("rstb_keep", 32'(dut_a.ram[8'h10]), 32'h0000_00DE);

        // MemEN high: request is ignored.
        @(negedge clk);
        mfa = 1'b1; memen = 1'b1; r_w = 1'b1; data_type = 2'b00; addr = 8'h40; data_in = 32'hAA;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (mfc) seen = 1'b1;
        end
        chk("memen_ign", 32'(seen), 32'd0);
        @(negedge clk); mfa = 1'b0;
        @(posedge clk);

        // Random mix of sizes, directions and alignments.
        for (int n = 0; n < 60; n++) begin
            rw = 1'($urandom);
            dt = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            if (dt != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~8'((1 << dt) - 1);
            do_access(rw, dt, a, $urandom);
        end
        for (int i = 0; i < 256; i++)
            chk("ram_final", 32'(dut_a.ram[i]), 32'(mem_m[i]));

        // Zero wait states, little-endian instance.
        @(negedge clk);
        mfa_b = 1'b1; memen_b = 1'b0; r_w_b = 1'b1; data_type_b = 2'b10;
        addr_b = 8'h00; data_in_b = 32'h01020304;
        @(posedge clk); #1;
        chk("b_cap_mfc", 32'(mfc_b), 32'd0);
        @(posedge clk); #1;
        chk("b_lat_mfc", 32'(mfc_b), 32'd1);
        chk("b_ram0", 32'(dut_b.ram[0]), 32'h04);
        chk("b_ram3", 32'(dut_b.ram[3]), 32'h01);
        @(negedge clk); mfa_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mfa_b = 1'b1; r_w_b = 1'b0; data_type_b = 2'b01; addr_b = 8'h02;
        @(posedge clk);
        @(posedge clk); #1;
        chk("b_half_mfc", 32'(mfc_b), 32'd1);
        chk("b_half_rd", data_out_b, 32'h0000_0102);
        @(negedge clk); mfa_b = 1'b0;
        @(posedge clk); #1;
        chk("b_mfc_clr", 32'(mfc_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
